// File: rtl/unsigned_accumulate_if.sv
// Sample-in / block-sum-out bundle for unsigned_accumulate; the slave modport is the accumulator side.
// i_* are driven toward the accumulator and o_* come back from it.
interface unsigned_accumulate_if #(
  parameter int INWID = 32,
  parameter int CNTW  = 8
);
  localparam int OUTWID = INWID + CNTW;

  logic              i_valid;
  logic              o_ready;
  logic [INWID-1:0]  i_data;
  logic [CNTW-1:0]   i_len;
  logic              i_clear;
  logic              o_valid;
  logic              i_ready;
  logic [OUTWID-1:0] o_sum;
  logic              o_busy;

  modport master (
    output i_valid, i_data, i_len, i_clear, i_ready,
    input  o_ready, o_valid, o_sum, o_busy
  );

  modport slave (
    input  i_valid, i_data, i_len, i_clear, i_ready,
    output o_ready, o_valid, o_sum, o_busy
  );
endinterface

// File: rtl/unsigned_accumulate.sv
// Block accumulator: sums 1..2^CNTW unsigned samples; the sum is valid one cycle after the final sample.
// Only a final sample stalls, and only while an earlier sum is still unconsumed.
module unsigned_accumulate #(
  parameter int INWID = 32,
  parameter int CNTW  = 8
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  unsigned_accumulate_if.slave bus
);
  localparam int OUTWID = INWID + CNTW;

  logic [OUTWID-1:0] r_acc;
  logic [OUTWID-1:0] r_sum;
  logic [CNTW-1:0]   r_cnt;
  logic [CNTW-1:0]   r_len_q;
  logic              r_valid;

  logic              w_last;
  logic              w_ready;
  logic              w_accept;
  logic              w_final;
  logic [OUTWID-1:0] w_acc_next;

  // The first sample of a block has no latched length yet, so use i_len directly.
  assign w_last     = (r_cnt == '0) ? (bus.i_len == '0) : (r_cnt == r_len_q);
  assign w_ready    = !(r_valid && !bus.i_ready && w_last);
  assign w_accept   = bus.i_valid && w_ready && !bus.i_clear;
  assign w_final    = w_accept && w_last;
  assign w_acc_next = r_acc + OUTWID'(bus.i_data);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_len_q <= '0;
      r_sum   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (bus.i_clear) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_accept) begin
        if (r_cnt == '0) begin
          r_len_q <= bus.i_len;
        end
        if (w_last) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CNTW'(1);
        end
      end

      // A new final sample in the same cycle as a consume keeps o_valid high.
      if (w_final) begin
        r_sum   <= w_acc_next;
        r_valid <= 1'b1;
      end else if (r_valid && bus.i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.o_ready = w_ready;
  assign bus.o_valid = r_valid;
  assign bus.o_sum   = r_sum;
  assign bus.o_busy  = (r_cnt != '0);
endmodule

// File: tb/tb_unsigned_accumulate.sv
// Scoreboard bench for unsigned_accumulate (INWID=8, CNTW=2): expected sums are queued on final accept
// and compared whenever the DUT hands a sum downstream.
module tb_unsigned_accumulate;
  localparam int INWID = 8;
  localparam int CNTW  = 2;

  logic i_clk;
  logic i_rst_n;

  unsigned_accumulate_if #(.INWID(INWID), .CNTW(CNTW)) bus();

  unsigned_accumulate #(.INWID(INWID), .CNTW(CNTW)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  int m_acc = 0;
  int m_cnt = 0;
  int m_len = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  // A sum transfers at the next rising edge whenever o_valid && i_ready holds at the falling edge.
  always @(negedge i_clk) begin
    if (i_rst_n && bus.o_valid && bus.i_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 32'(bus.o_sum), 32'hFFFF_FFFF);
      else                   chk("sum", 32'(bus.o_sum), 32'(exp_q.pop_front()));
    end
  end

  task automatic send(input int d, input int len);
    int waited;
    waited = 0;
    bus.i_valid = 1'b1;
    bus.i_data  = 8'(d);
    bus.i_len   = 2'(len);
    @(negedge i_clk);
    while (!bus.o_ready && waited < 50) begin
      waited++;
      @(negedge i_clk);
    end
    if (waited >= 50) chk("ready_timeout", 32'(waited), 32'd0);
    @(posedge i_clk);
    if (m_cnt == 0) m_len = len;
    m_acc += d;
    if (m_cnt == m_len) begin
      exp_q.push_back(m_acc);
      m_acc = 0;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin
    int waited;
    i_rst_n     = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_len   = '0;
    bus.i_clear = 1'b0;
    bus.i_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_sum",   32'(bus.o_sum),   32'd0);
    chk("rst_busy",  32'(bus.o_busy),  32'd0);
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(2);

    // 1. basic sum with output latency
    send(10, 3); send(20, 3); send(30, 3);
    chk("t1_busy", 32'(bus.o_busy), 32'd1);
    fork
      send(40, 3);
      begin
        @(negedge i_clk);
        chk("t1_valid_before", 32'(bus.o_valid), 32'd0);
        @(negedge i_clk);
        chk("t1_valid_after", 32'(bus.o_valid), 32'd1);
      end
    join
    idle(2);

    // 2. maximum value, then a length-1 block
    repeat (4) send(255, 3);
    send(50, 0);
    idle(2);
    chk("t2_idle_valid", 32'(bus.o_valid), 32'd0);

    // 3. backpressure stalls only the final sample
    bus.i_ready = 1'b0;
    send(1, 1); send(2, 1);
    send(4, 2); send(5, 2);
    fork
      send(6, 2);
      begin
        @(negedge i_clk);
        chk("t3_stall_ready", 32'(bus.o_ready), 32'd0);
        chk("t3_hold_sum",    32'(bus.o_sum),   32'd3);
        chk("t3_hold_valid",  32'(bus.o_valid), 32'd1);
        @(negedge i_clk);
        chk("t3_stall_ready2", 32'(bus.o_ready), 32'd0);
        @(posedge i_clk);
        #1;
        bus.i_ready = 1'b1;
      end
    join
    idle(3);

    // 4. back-to-back length-1 blocks
    fork
      begin send(7, 0); send(8, 0); send(9, 0); end
      begin
        @(negedge i_clk);
        chk("t4_ready0", 32'(bus.o_ready), 32'd1);
        @(negedge i_clk);
        chk("t4_ready1", 32'(bus.o_ready), 32'd1);
        chk("t4_valid1", 32'(bus.o_valid), 32'd1);
        @(negedge i_clk);
        chk("t4_ready2", 32'(bus.o_ready), 32'd1);
        chk("t4_valid2", 32'(bus.o_valid), 32'd1);
        @(negedge i_clk);
        chk("t4_valid3", 32'(bus.o_valid), 32'd1);
      end
    join
    idle(3);

    // 5. clear drops the sample and the partial block but keeps a pending sum
    bus.i_ready = 1'b0;
    send(77, 0);
    send(5, 3); send(6, 3);
    bus.i_valid = 1'b1;
    bus.i_data  = 8'd99;
    bus.i_clear = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_clear = 1'b0;
    m_acc = 0;
    m_cnt = 0;
    chk("t5_busy",  32'(bus.o_busy),  32'd0);
    chk("t5_valid", 32'(bus.o_valid), 32'd1);
    chk("t5_sum",   32'(bus.o_sum),   32'd77);
    bus.i_ready = 1'b1;
    repeat (4) send(1, 3);
    idle(3);

    // 6. asynchronous reset mid-block discards partial and pending results
    bus.i_ready = 1'b0;
    send(9, 0);
    send(3, 3); send(3, 3);
    chk("t6_busy_pre", 32'(bus.o_busy), 32'd1);
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.o_valid), 32'd0);
    chk("t6_rst_sum",   32'(bus.o_sum),   32'd0);
    chk("t6_rst_busy",  32'(bus.o_busy),  32'd0);
    exp_q.delete();
    m_acc = 0;
    m_cnt = 0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    bus.i_ready = 1'b1;
    idle(1);
    repeat (4) send(2, 3);

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      waited++;
      @(posedge i_clk);
    end
    idle(2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
